// File: rtl/tetris_pkg.sv
// Shared encodings for the falling-piece datapath: command and block codes, sequencer states, board size.
package tetris_pkg;

  localparam int COLS_DEF    = 10;
  localparam int ROWS_DEF    = 20;
  localparam int XW_DEF      = 4;
  localparam int YW_DEF      = 5;
  localparam int SPAWN_X_DEF = 4;

  typedef enum logic [2:0] {
    CMD_LEFT   = 3'd0,
    CMD_RIGHT  = 3'd1,
    CMD_DOWN   = 3'd2,
    CMD_ROTATE = 3'd3,
    CMD_SPAWN  = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    BLK_I = 3'd0,
    BLK_J = 3'd1,
    BLK_L = 3'd2,
    BLK_O = 3'd3,
    BLK_S = 3'd4,
    BLK_T = 3'd5,
    BLK_Z = 3'd6
  } blk_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_TAIL  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/piece_ctrl.sv
// Active-piece sequencer: builds a candidate pose per command, probes its 4 cells against the board, commits if all free.
// Latency 6 cycles accept->resp (1 for a fast reject); cmd_ready only in IDLE, commands seen while busy are dropped.
module piece_ctrl
  import tetris_pkg::*;
#(
  parameter int COLS    = COLS_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int XW      = XW_DEF,
  parameter int YW      = YW_DEF,
  parameter int SPAWN_X = SPAWN_X_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd,
  input  logic [2:0]    cmd_block,
  output logic [2:0]    lut_block,
  output logic [1:0]    lut_rotation,
  input  logic [7:0]    lut_x,
  input  logic [7:0]    lut_y,
  output logic          occ_rd,
  output logic [XW-1:0] occ_x,
  output logic [YW-1:0] occ_y,
  input  logic          occ_q,
  output logic          resp_valid,
  output logic          resp_ok,
  output logic          landed,
  output logic          game_over,
  output logic          piece_active,
  output logic [XW-1:0] piece_x,
  output logic [YW-1:0] piece_y,
  output logic [1:0]    piece_rot,
  output logic [2:0]    piece_block
);

  localparam logic [XW:0] COLS_W  = (XW+1)'(COLS);
  localparam logic [YW:0] ROWS_W  = (YW+1)'(ROWS);
  localparam logic [XW:0] SPAWN_W = (XW+1)'(SPAWN_X);

  state_e        state_q;
  logic [XW:0]   cand_x_q;
  logic [YW:0]   cand_y_q;
  logic [1:0]    cand_rot_q;
  logic [2:0]    cand_blk_q;
  logic          is_down_q;
  logic          is_spawn_q;
  logic [1:0]    cell_q;
  logic          coll_q;
  logic          rd_prev_q;
  logic          active_q;
  logic          over_q;
  logic [XW-1:0] piece_x_q;
  logic [YW-1:0] piece_y_q;
  logic [1:0]    piece_rot_q;
  logic [2:0]    piece_blk_q;
  logic          resp_valid_q;
  logic          resp_ok_q;
  logic          landed_q;

  logic [XW:0]   cand_x_d;
  logic [YW:0]   cand_y_d;
  logic [1:0]    cand_rot_d;
  logic [2:0]    cand_blk_d;
  logic          fast_rej_d;

  logic [1:0]    dx;
  logic [1:0]    dy;
  logic [XW:0]   cx;
  logic [YW:0]   cy;
  logic          oob;
  logic          occ_rd_d;
  logic          coll_d;

  // Candidate pose from the committed pose; extra MSB lets x go to -1 without aliasing.
  always_comb begin
    cand_x_d   = {1'b0, piece_x_q};
    cand_y_d   = {1'b0, piece_y_q};
    cand_rot_d = piece_rot_q;
    cand_blk_d = piece_blk_q;
    case (cmd)
      CMD_LEFT:   cand_x_d   = {1'b0, piece_x_q} - (XW+1)'(1);
      CMD_RIGHT:  cand_x_d   = {1'b0, piece_x_q} + (XW+1)'(1);
      CMD_DOWN:   cand_y_d   = {1'b0, piece_y_q} + (YW+1)'(1);
      CMD_ROTATE: cand_rot_d = piece_rot_q + 2'd1;
      CMD_SPAWN: begin
        cand_x_d   = SPAWN_W;
        cand_y_d   = '0;
        cand_rot_d = 2'd0;
        cand_blk_d = cmd_block;
      end
      default: ;
    endcase
    fast_rej_d = over_q || (cmd > CMD_SPAWN) || ((cmd != CMD_SPAWN) && !active_q);
  end

  // Cell address and bounds check for the cell currently being probed.
  always_comb begin
    dx       = lut_x[{cell_q, 1'b0} +: 2];
    dy       = lut_y[{cell_q, 1'b0} +: 2];
    cx       = cand_x_q + {{(XW-1){1'b0}}, dx};
    cy       = cand_y_q + {{(YW-1){1'b0}}, dy};
    oob      = cx[XW] || (cx >= COLS_W) || (cy >= ROWS_W);
    occ_rd_d = (state_q == ST_CHECK) && !oob;
    coll_d   = coll_q || (rd_prev_q && occ_q) || ((state_q == ST_CHECK) && oob);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      cand_rot_q   <= 2'd0;
      cand_blk_q   <= 3'd0;
      is_down_q    <= 1'b0;
      is_spawn_q   <= 1'b0;
      cell_q       <= 2'd0;
      coll_q       <= 1'b0;
      rd_prev_q    <= 1'b0;
      active_q     <= 1'b0;
      over_q       <= 1'b0;
      piece_x_q    <= SPAWN_W[XW-1:0];
      piece_y_q    <= '0;
      piece_rot_q  <= 2'd0;
      piece_blk_q  <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      landed_q     <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      landed_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            cand_rot_q <= cand_rot_d;
            cand_blk_q <= cand_blk_d;
            is_down_q  <= (cmd == CMD_DOWN);
            is_spawn_q <= (cmd == CMD_SPAWN);
            cell_q     <= 2'd0;
            coll_q     <= 1'b0;
            rd_prev_q  <= 1'b0;
            if (fast_rej_d) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          coll_q    <= coll_d;
          rd_prev_q <= occ_rd_d;
          cell_q    <= cell_q + 2'd1;
          if (cell_q == 2'd3) begin
            state_q <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          // coll_d here folds in the read result of the last cell.
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          if (!coll_d) begin
            piece_x_q   <= cand_x_q[XW-1:0];
            piece_y_q   <= cand_y_q[YW-1:0];
            piece_rot_q <= cand_rot_q;
            piece_blk_q <= cand_blk_q;
            resp_ok_q   <= 1'b1;
            if (is_spawn_q) begin
              active_q <= 1'b1;
            end
          end else if (is_spawn_q) begin
            over_q   <= 1'b1;
            active_q <= 1'b0;
          end else if (is_down_q) begin
            landed_q <= 1'b1;
            active_q <= 1'b0;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign lut_block    = cand_blk_q;
  assign lut_rotation = cand_rot_q;
  assign occ_rd       = occ_rd_d;
  assign occ_x        = occ_rd_d ? cx[XW-1:0] : '0;
  assign occ_y        = occ_rd_d ? cy[YW-1:0] : '0;
  assign resp_valid   = resp_valid_q;
  assign resp_ok      = resp_ok_q;
  assign landed       = landed_q;
  assign game_over    = over_q;
  assign piece_active = active_q;
  assign piece_x      = piece_x_q;
  assign piece_y      = piece_y_q;
  assign piece_rot    = piece_rot_q;
  assign piece_block  = piece_blk_q;

endmodule

// File: doc/piece_ctrl.md
Name: piece_ctrl

Overview:
Sequencer for the active falling tetromino. It accepts move, rotate, drop and spawn commands, and for each one builds a candidate pose. It then steps the four cells of that pose through the shape lookup table and the board occupancy read port, and commits the pose only when every cell is in bounds and free. It sits between the game FSM/input debouncer (upstream) and the board RAM, shape LUT and renderer (downstream).

Parameters:
COLS, 10, board width in cells
ROWS, 20, board height in cells
XW, 4, x coordinate width
YW, 5, y coordinate width
SPAWN_X, 4, x origin of a newly spawned piece

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when state==IDLE
cmd  in  3  0=LEFT 1=RIGHT 2=DOWN 3=ROTATE 4=SPAWN; 5-7 are illegal
cmd_block  in  3  piece type for SPAWN (0=I 1=J 2=L 3=O 4=S 5=T 6=Z)
lut_block  out  3  candidate block type to the shape LUT
lut_rotation  out  2  candidate rotation to the shape LUT
lut_x  in  8  packed 2-bit x offsets; cell k = bits [2k+1:2k]; combinational from lut_*
lut_y  in  8  packed 2-bit y offsets; same packing
occ_rd  out  1  board read strobe
occ_x  out  XW  board read column
occ_y  out  YW  board read row
occ_q  in  1  occupied flag; valid the cycle after occ_rd
resp_valid  out  1  one-cycle pulse: command finished
resp_ok  out  1  with resp_valid: 1 = committed, 0 = rejected
landed  out  1  with resp_valid: DOWN was rejected on an active piece
game_over  out  1  sticky; set when a SPAWN collides
piece_active  out  1  a piece is currently live
piece_x  out  XW  committed origin column
piece_y  out  YW  committed origin row
piece_rot  out  2  committed rotation
piece_block  out  3  committed block type

Behaviour:
- Reset values:
  - state=IDLE; piece_x=SPAWN_X; piece_y=0; piece_rot=0; piece_block=0.
  - piece_active=0; game_over=0.
  - resp_valid, resp_ok, landed, occ_rd = 0; occ_x, occ_y, lut_* = 0.
  - Reset mid-command abandons the command; no response is issued.
- States: IDLE, CHECK, TAIL, RESP. cmd_ready=1 only in IDLE.
- Accept cycle T (cmd_valid && cmd_ready) registers the candidate pose:
  - LEFT: x-1. RIGHT: x+1. DOWN: y+1.
  - ROTATE: rot+1 mod 4 (3 wraps to 0).
  - SPAWN: x=SPAWN_X, y=0, rot=0, block=cmd_block.
- Fast reject: any of the following goes straight to RESP at T+1 with resp_ok=0, landed=0, and issues no reads:
  - a non-SPAWN command while !piece_active;
  - any command while game_over;
  - an illegal cmd code.
- Candidate arithmetic is done at XW+1 / YW+1 bits. A cell is out of bounds when cx<0, cx>=COLS or cy>=ROWS.
- CHECK (T+1..T+4), for cell index k=0..3:
  - cx = cand_x + lut_x[k] and cy = cand_y + lut_y[k].
  - In-bounds cell: occ_rd=1, occ_x=cx, occ_y=cy.
  - Out-of-bounds cell: occ_rd=0 and a collision flag is set.
- lut_block and lut_rotation hold the candidate pose throughout CHECK.
- occ_q for cell k is sampled at T+2+k (only when that cell was read) and ORed into the collision flag.
- TAIL (T+5) samples the final occ_q.
- RESP (T+6), one cycle, with resp_valid=1:
  - No collision: piece_* take the candidate values on this edge (visible at T+6); resp_ok=1. SPAWN also sets piece_active=1.
  - Collision on SPAWN: game_over=1, piece_active=0.
  - Collision on DOWN: landed=1, piece_active=0. The upper FSM locks the piece into the board.
  - The next cycle is IDLE. Fixed throughput: one command per 7 cycles, or 2 cycles for a fast reject.
- cmd_valid in non-IDLE states is ignored (not queued).
- For the O block (code 3), ROTATE checks the same cells and commits the new rot value.

Decomposition:
- Package tetris_pkg holds:
  - command codes CMD_LEFT..CMD_SPAWN;
  - block codes BLK_I..BLK_Z;
  - state encoding;
  - COLS/ROWS defaults.
- The shape LUT is instantiated beside piece_ctrl by the parent and is not a child of this block.
- No sub-module; the cell address adder and bounds check stay inline.

Test Plan:
- reset, SPAWN block=1 on an empty board -> reads at T+1..T+4, resp_valid at T+6, resp_ok=1, piece_x=4, piece_y=0, piece_active=1.
- I piece at x=0, rot=0, LEFT -> cell x=-1 flagged, no occ_rd for that cell, resp_ok=0, piece_x stays 0, landed=0.
- T piece with y such that y+1+max dy = 20, DOWN -> resp_ok=0, landed=1, piece_active=0.
- ROTATE at rot=3 on an empty board -> resp_ok=1, piece_rot=0; a model board with occupied cell (5,1), checked with a J piece at (4,0) -> rejected.
- SPAWN with occ_q=1 at (5,0), block=0 -> game_over=1; a following RIGHT -> resp at T+1 with resp_ok=0 and no occ_rd.
- cmd_valid held high during CHECK with cmd=2 -> ignored; reset asserted at T+3 -> no resp_valid, all outputs back to reset values the next cycle.
